// File: rtl/riscv_muldiv_pkg.sv
// Shared constants, op encodings and FSM state type for the RV32M multiply/divide unit.
package riscv_muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = $clog2(ITER);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // MUL is treated as unsigned: the low product half is sign-agnostic.
  function automatic logic a_is_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/riscv_muldiv_abs.sv
// Conditional two's-complement negate, used for operand magnitudes and the final sign fix.
module muldiv_abs #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] value_i,
  input  logic         negate_en_i,
  output logic [W-1:0] value_c_o
);

  assign value_c_o = negate_en_i ? (~value_i + W'(1)) : value_i;

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit (shift-add / restoring divide, 32 iterations).
// Define MULDIV_FAST_SPECIAL_EN to resolve divide-by-zero and signed overflow in one cycle.
module riscv_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  import riscv_muldiv_pkg::*;

  localparam int unsigned DW = 2 * XLEN;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DW-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic [XLEN-1:0]   a_raw_q, a_raw_d;
  logic              sign_q, sign_d;
  logic              div0_q, div0_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   result_d;
  logic              zero_d, busy_d, done_d;
`ifdef MULDIV_FAST_SPECIAL_EN
  logic              pend_q, pend_d;
`endif

  logic              neg_a_c, neg_b_c, div0_c, ovf_c, accept_c;
  logic [XLEN-1:0]   abs_a_c, abs_b_c;
  logic [DW-1:0]     fix_in_c, fix_out_c;
  logic [XLEN-1:0]   fix_sel_c, spec_val_c;
  logic [XLEN:0]     mul_sum_c, rem_sh_c;
  logic [XLEN-1:0]   rem_sub_c;
  logic              rem_ge_c;

  assign neg_a_c = a_is_signed(op) & a[XLEN-1];
  assign neg_b_c = b_is_signed(op) & b[XLEN-1];
  assign div0_c  = op[2] & (b == '0);
  assign ovf_c   = op[2] & ~op[0] & (a == INT_MIN) & (&b);

  muldiv_abs #(.W(XLEN)) u_abs_a (.value_i(a), .negate_en_i(neg_a_c), .value_c_o(abs_a_c));
  muldiv_abs #(.W(XLEN)) u_abs_b (.value_i(b), .negate_en_i(neg_b_c), .value_c_o(abs_b_c));

  // Divide results sit in the low half so one wide negator serves both paths.
  assign fix_in_c = op_q[2] ? {{XLEN{1'b0}}, (op_q[1] ? acc_q[DW-1:XLEN] : acc_q[XLEN-1:0])}
                            : acc_q;
  muldiv_abs #(.W(DW)) u_fix (.value_i(fix_in_c), .negate_en_i(sign_q), .value_c_o(fix_out_c));

  assign fix_sel_c  = (op_q[2] || (op_q == OP_MUL)) ? fix_out_c[XLEN-1:0] : fix_out_c[DW-1:XLEN];
  assign spec_val_c = op_q[1] ? (div0_q ? a_raw_q : '0) : (div0_q ? '1 : INT_MIN);

  // Iteration datapath: acc holds {partial, multiplier} or {remainder, quotient/dividend}.
  assign mul_sum_c = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, dvsr_q} : '0);
  assign rem_sh_c  = {acc_q[DW-1:XLEN], acc_q[XLEN-1]};
  assign rem_ge_c  = rem_sh_c >= {1'b0, dvsr_q};
  assign rem_sub_c = rem_sh_c[XLEN-1:0] - dvsr_q;

`ifdef MULDIV_FAST_SPECIAL_EN
  assign accept_c = start & ((state_q == IDLE) | (state_q == DONE)) & ~pend_q;
`else
  assign accept_c = start & ((state_q == IDLE) | (state_q == DONE));
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    count_d  = count_q;
    acc_d    = acc_q;
    dvsr_d   = dvsr_q;
    a_raw_d  = a_raw_q;
    sign_d   = sign_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    result_d = result;
    zero_d   = zero;
`ifdef MULDIV_FAST_SPECIAL_EN
    pend_d   = pend_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
`ifdef MULDIV_FAST_SPECIAL_EN
        if (pend_q) begin
          result_d = spec_val_c;
          zero_d   = (spec_val_c == '0);
          pend_d   = 1'b0;
          state_d  = DONE;
        end
`endif
        if (accept_c) begin
          op_d    = op;
          count_d = '0;
          a_raw_d = a;
          div0_d  = div0_c;
          ovf_d   = ovf_c;
          sign_d  = (op[2] & op[1]) ? neg_a_c : (neg_a_c ^ neg_b_c);
          acc_d   = {{XLEN{1'b0}}, (op[2] ? abs_a_c : abs_b_c)};
          dvsr_d  = op[2] ? abs_b_c : abs_a_c;
          state_d = CALC;
`ifdef MULDIV_FAST_SPECIAL_EN
          if (div0_c | ovf_c) begin
            pend_d  = 1'b1;
            state_d = IDLE;
          end
`endif
        end
      end
      CALC: begin
        if (op_q[2]) begin
          acc_d = rem_ge_c ? {rem_sub_c, acc_q[XLEN-2:0], 1'b1}
                           : {rem_sh_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum_c, acc_q[XLEN-1:1]};
        end
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST) state_d = FIX;
      end
      FIX: begin
        result_d = (div0_q | ovf_q) ? spec_val_c : fix_sel_c;
        zero_d   = (result_d == '0);
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      zero    <= 1'b1;
      count_q <= '0;
`ifdef MULDIV_FAST_SPECIAL_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
      result  <= result_d;
      zero    <= zero_d;
      count_q <= count_d;
`ifdef MULDIV_FAST_SPECIAL_EN
      pend_q  <= pend_d;
`endif
    end
  end

  // Operand and iteration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_MUL;
      acc_q   <= '0;
      dvsr_q  <= '0;
      a_raw_q <= '0;
      sign_q  <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      op_q    <= op_d;
      acc_q   <= acc_d;
      dvsr_q  <= dvsr_d;
      a_raw_q <= a_raw_d;
      sign_q  <= sign_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed-vector bench for riscv_muldiv: latency, handshake, results, reset.
module tb_riscv_muldiv;
  import riscv_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, zero;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif

  always #5 clk = ~clk;

  riscv_muldiv dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one op, then measure edges from the start edge until done.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_r, input logic exp_z,
                        input int exp_lat);
    int  k;
    bit  busy_ok;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    busy_ok = 1'b1;
    while (!done && k < 100) begin
      if (busy !== (exp_lat > 1)) busy_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    chk({name, "_latency"}, 32'(k), 32'(exp_lat));
    chk({name, "_busy"}, {31'b0, busy_ok}, 32'd1);
    chk({name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    chk({name, "_result"}, result, exp_r);
    chk({name, "_zero"}, {31'b0, zero}, {31'b0, exp_z});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int k;
    int first_done;
    bit saw_done;

    vecs[0]  = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33};
    vecs[1]  = '{OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 1'b0, 33};
    vecs[2]  = '{OP_MUL,    32'd0,        32'h0000FFFF, 32'h00000000, 1'b1, 33};
    vecs[3]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 33};
    vecs[4]  = '{OP_MULH,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0, 33};
    vecs[5]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33};
    vecs[6]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33};
    vecs[7]  = '{OP_DIV,    32'hFFFFFFEC, 32'd6,        32'hFFFFFFFD, 1'b0, 33};
    vecs[8]  = '{OP_REM,    32'hFFFFFFEC, 32'd6,        32'hFFFFFFFE, 1'b0, 33};
    vecs[9]  = '{OP_DIVU,   32'd20,       32'd6,        32'd3,        1'b0, 33};
    vecs[10] = '{OP_REMU,   32'd20,       32'd6,        32'd2,        1'b0, 33};
    vecs[11] = '{OP_DIVU,   32'd3,        32'd7,        32'd0,        1'b1, 33};
    vecs[12] = '{OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33};
    vecs[13] = '{OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        1'b0, 33};
    vecs[14] = '{OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, SPEC_LAT};
    vecs[15] = '{OP_REMU,   32'd5,        32'd0,        32'd5,        1'b0, SPEC_LAT};
    vecs[16] = '{OP_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b0, SPEC_LAT};
    vecs[17] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, SPEC_LAT};
    vecs[18] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, SPEC_LAT};

    repeat (2) @(negedge clk);
    chk("reset_busy",   {31'b0, busy}, 32'd0);
    chk("reset_done",   {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_zero",   {31'b0, zero}, 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].z, vecs[i].lat);
    end

    // Start while busy is ignored; start in the DONE cycle is accepted.
    @(negedge clk);
    start = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    first_done = -1;
    while (k < 100 && first_done < 0) begin
      if (done) first_done = k;
      else begin
        if (k == 4) begin start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3; end
        if (k == 5) start = 1'b0;
        @(negedge clk);
        k++;
      end
    end
    chk("busy_start_latency", 32'(first_done), 32'd33);
    chk("busy_start_result", result, 32'd12);
    start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("done_issue_busy", {31'b0, busy}, 32'd1);
    chk("done_issue_done", {31'b0, done}, 32'd0);
    k = 1;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("done_issue_spacing", 32'(k), 32'd34);
    chk("done_issue_result", result, 32'd3);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; op = OP_MUL; a = 32'h1234; b = 32'h10;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy",   {31'b0, busy}, 32'd0);
    chk("midreset_done",   {31'b0, done}, 32'd0);
    chk("midreset_result", result, 32'd0);
    chk("midreset_zero",   {31'b0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("midreset_no_done", {31'b0, saw_done}, 32'd0);
    run_op("post_reset_mul", OP_MUL, 32'd2, 32'd5, 32'd10, 1'b0, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_muldiv.md
# riscv_muldiv

Iterative multi-cycle multiply/divide unit for the RV32M extension. It is the responder on the same operand/result interface the ALU presents: a and b in, result and zero out, plus a start/busy/done handshake. It sits beside the single-cycle ALU in the execute stage. The control path stalls the core while busy is high and captures result on done.

## Interface
Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request strobe. Sampled only when busy=0.
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  rs1 operand. Sampled with start.
- b  in  XLEN  rs2 operand. Sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result and zero are valid from this cycle.
- result  out  XLEN  registered result. Held until the next accepted start.
- zero  out  1  registered (result == 0).

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start=1: latch op, |a| and |b| (per signedness) and the result sign, clear count, go to CALC. Otherwise DONE goes to IDLE.
- CALC: one iteration per cycle for 32 cycles. count runs 0..31; at count=31 the state goes to FIX.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract giving a 32-bit quotient and a 32-bit remainder.
- FIX: apply sign correction and select the low or high half, or quotient or remainder. Register result and zero, then go to DONE.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV: quotient is negative when the operand signs differ.
  - REM: remainder takes the sign of a.
- Divide special cases (RISC-V rules):
  - b=0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- busy = (state is CALC or FIX).
- done = (state is DONE).
- start while busy=1 is ignored. No queueing; operands are not re-sampled.
- start in the DONE cycle is accepted. done still pulses, and busy rises on the next cycle.
- Reset (any time, including mid-operation): state IDLE; busy=0, done=0, result=0, zero=1, count=0. The in-flight operation is discarded.

## Timing
- Start sampled at edge E0. CALC iterations occur at E1..E32, FIX registers the result at E33, and done is high for the cycle E33..E34.
- Latency from start edge to done is 33 cycles. Back-to-back issue gives 34 cycles per operation.
- busy is high E1..E33.
- result and zero change only at the FIX edge (or at the special-case edge, see Configuration).

## Configuration
- MULDIV_FAST_SPECIAL_EN defined:
  - Divide-by-zero and signed overflow skip CALC/FIX; the special value is registered at E1 and done is high for E1..E2.
  - Latency is 1 cycle; busy stays 0 throughout.
- MULDIV_FAST_SPECIAL_EN undefined:
  - These cases run the full 33-cycle sequence.
  - The result is produced by the FIX override and has identical values.
- All other operations are unaffected.

## Structure
- Package riscv_muldiv_pkg holds:
  - the op encoding constants (OP_MUL … OP_REMU);
  - the state typedef (IDLE, CALC, FIX, DONE);
  - XLEN and the iteration count constant (32).
- Sub-module muldiv_abs: conditional two's-complement negate (input, negate_en → output). It is instantiated for the a and b absolute values and for the final sign fix.

## Test plan
- MUL a=7, b=0xFFFFFFFD, start one cycle → busy E1..E33, done only at E33, result=0xFFFFFFEB, zero=0.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFEC/6 → 0xFFFFFFFD; REM → 0xFFFFFFFE. DIVU 20/6 → 3; REMU → 2. DIVU 3/7 → 0 with zero=1.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0 with zero=1.
  - done at E1 with MULDIV_FAST_SPECIAL_EN defined, at E33 without.
- Start MUL 3×4; pulse start with DIVU 9/3 at E5 → ignored, result=12 at E33. Then issue DIVU 9/3 in the DONE cycle → result=3, done 34 cycles after the first done.
- Assert rst_n=0 at E10 of a MUL → immediately busy=0, done=0, result=0, zero=1. No done pulse follows. A subsequent MUL 2×5 returns 10.
